// File: rtl/prog_loader.sv
// Framed byte-stream loader: SYNC, address, length, payload, optional checksum.
// Define PROG_LOADER_CSUM_EN to append and verify an 8-bit additive checksum.
module prog_loader #(
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
`ifdef PROG_LOADER_CSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  logic acc;
  logic active;

  assign in_ready  = (state_q != S_DONE) && (state_q != S_ERR);
  assign acc       = in_valid && in_ready;
  assign active    = in_ready && (state_q != S_IDLE);
  assign cpu_hold  = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef PROG_LOADER_CSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef PROG_LOADER_CSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef PROG_LOADER_CSUM_EN
    sum_d   = sum_q;
`endif
    // abort wins over any byte presented in the same cycle
    if (abort && active) begin
      state_d = S_ERR;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (acc && in_data == SYNC_BYTE) state_d = S_ADDR;
        end
        S_ADDR: begin
          if (acc) begin
            ptr_d   = in_data[ADDR_W-1:0];
            state_d = S_LEN;
          end
        end
        S_LEN: begin
          if (acc) begin
            cnt_d = in_data;
`ifdef PROG_LOADER_CSUM_EN
            sum_d   = 8'h00;
            state_d = (in_data == 8'h00) ? S_CSUM : S_DATA;
`else
            state_d = (in_data == 8'h00) ? S_DONE : S_DATA;
`endif
          end
        end
        S_DATA: begin
          if (acc) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = in_data[DATA_W-1:0];
            ptr_d   = ptr_q + ADDR_W'(1);
            cnt_d   = cnt_q - 8'd1;
`ifdef PROG_LOADER_CSUM_EN
            sum_d = sum_q + in_data;
            if (cnt_q == 8'd1) state_d = S_CSUM;
`else
            if (cnt_q == 8'd1) state_d = S_DONE;
`endif
          end
        end
`ifdef PROG_LOADER_CSUM_EN
        S_CSUM: begin
          if (acc) state_d = (in_data == sum_q) ? S_DONE : S_ERR;
        end
`endif
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule
